ball_event_detector: RTL and testbench
======================================

Name: ball_event_detector

Overview:
Per-ball event source for the game controller. Samples one ball's position and velocity on each startOfFrame, scans the six table holes sequentially, and issues a one-cycle hole-hit pulse with the hole number. Also maintains a debounced "ball stopped" level. One instance per ball (white, red); its outputs drive the controller's xBallHoleHit, redBallHoleNum and xBallStopped inputs.

Parameters:
TABLE_LEFT, 11'd32, x of left pocket centres (holes 1, 4)
TABLE_RIGHT, 11'd607, x of right pocket centres (holes 3, 6)
TABLE_TOP, 11'd64, y of top pocket centres (holes 1-3)
TABLE_BOTTOM, 11'd447, y of bottom pocket centres (holes 4-6)
HOLE_RADIUS, 8'd12, capture radius in pixels, inclusive
SPEED_EPS, 11'd0, max |speed| per axis still counted as "still"
STOP_FRAMES, 4'd4, consecutive still frames required to assert ballStopped (1..15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
startOfFrame  in  1  one-cycle frame strobe
ballShow  in  1  ball currently on table
ballX  in  11  ball centre x, unsigned
ballY  in  11  ball centre y, unsigned
ballSpeedX  in  11  signed x velocity
ballSpeedY  in  11  signed y velocity
ballHoleHit  out  1  one-cycle pulse: ball captured by a hole
ballHoleNum  out  3  hole number 1..6, valid with and held after ballHoleHit
ballStopped  out  1  level: ball judged stationary

Behaviour:
- Reset (sync, high): all outputs 0, FSM to S_IDLE, stillCnt=0, armed=1. Reset mid-scan aborts the scan; no pulse.
- Hole map: 1=(LEFT,TOP) 2=(MID,TOP) 3=(RIGHT,TOP) 4=(LEFT,BOTTOM) 5=(MID,BOTTOM) 6=(RIGHT,BOTTOM), MID=(LEFT+RIGHT)>>1 (319 by default).
- FSM states S_IDLE, S_SCAN, S_REPORT.
- S_IDLE: on startOfFrame at cycle T, register X, Y, show and speeds, set idx=1, go to S_SCAN.
- S_SCAN: one hole per cycle, idx 1..6 in cycles T+1..T+6.
  - dx, dy: 12-bit signed. d2 = dx*dx + dy*dy: 24-bit unsigned.
  - Hit when d2 <= HOLE_RADIUS^2. On the first hit, latch idx as hitNum. Lower index wins if holes overlap.
  - After idx 6, go to S_REPORT.
- S_REPORT (cycle T+7):
  - If a hit occurred, sampled show=1 and armed=1: ballHoleHit=1 for this cycle, ballHoleNum<=hitNum, armed<=0.
  - Return to S_IDLE.
- startOfFrame during S_SCAN/S_REPORT: abort, resample, restart at idx=1; no pulse for the aborted frame.
- Re-arm: armed<=1 on any cycle where ballShow=0. At most one pulse per ball appearance, even if the ball lingers over a hole across frames.
- ballHoleNum holds its last value until the next pulse; 0 until the first hit.
- Stop detector, evaluated at T+1 using the sampled values:
  - still = show && |vx|<=SPEED_EPS && |vy|<=SPEED_EPS. Absolute value of -1024 saturates to 1023.
  - still: stillCnt increments, saturating at STOP_FRAMES.
  - not still: stillCnt<=0 and ballStopped<=0.
  - ballStopped<=1 when stillCnt reaches STOP_FRAMES, i.e. at T+1 of the STOP_FRAMES-th consecutive still frame.
- Sampled show=0: stillCnt<=0, ballStopped<=0, and no hit is reported.
- Inputs are ignored between frame strobes. No combinational path from inputs to outputs.

Test Plan:
1. Reset, ballShow=1, (32,64), speeds 0, strobe at T -> ballHoleHit=1 only at T+7, ballHoleNum=1. Next strobe, same position -> no pulse (armed=0). ballShow low for one cycle, then a further strobe -> pulse again with hole 1.
2. Boundary: (44,64) -> hit, num=1 (d2=144). (45,64) -> no pulse (d2=169). (327,447) -> hit, num=5.
3. Stop debounce, defaults: 3 still frames then vx=1 -> ballStopped stays 0. Then 4 still frames -> ballStopped=1 at T+1 of the 4th frame. vy=-1 next frame -> ballStopped=0 at T+1.
4. Abort: strobe at T, second strobe at T+3 with the position moved from hole 3 to (200,200) -> no pulse at T+7 or T+10.
5. Mid-scan reset: reset at T+4 of a hitting frame -> no pulse; all outputs 0. Next frame, same position -> pulse at T'+7.
6. Hidden ball: ballShow=0, at (607,447), speeds 0 for 6 frames -> no pulse, ballStopped=0 throughout.

Source files
------------

// File: rtl/ball_event_detector.sv
// ball_event_detector: per-ball event source. Each startOfFrame, it samples
// the ball's state. It then scans the six table holes one per cycle. At most
// one hole-hit pulse is issued per ball appearance. Separately, a debounced
// "ball stopped" level is maintained.
module ball_event_detector #(
  parameter logic [10:0] TABLE_LEFT   = 11'd32,
  parameter logic [10:0] TABLE_RIGHT  = 11'd607,
  parameter logic [10:0] TABLE_TOP    = 11'd64,
  parameter logic [10:0] TABLE_BOTTOM = 11'd447,
  parameter logic [7:0]  HOLE_RADIUS  = 8'd12,
  parameter logic [10:0] SPEED_EPS    = 11'd0,
  parameter logic [3:0]  STOP_FRAMES  = 4'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        ballShow,
  input  logic [10:0] ballX,
  input  logic [10:0] ballY,
  input  logic [10:0] ballSpeedX,
  input  logic [10:0] ballSpeedY,
  output logic        ballHoleHit,
  output logic [2:0]  ballHoleNum,
  output logic        ballStopped
);

  localparam logic [11:0] MID_SUM = {1'b0, TABLE_LEFT} + {1'b0, TABLE_RIGHT};
  localparam logic [10:0] TABLE_MID = MID_SUM[11:1];
  localparam logic [23:0] R2 = {16'd0, HOLE_RADIUS} * {16'd0, HOLE_RADIUS};

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_REPORT} state_t;

  state_t      state_q, state_d;
  logic [10:0] x_q, y_q;
  logic        show_q;
  logic [2:0]  idx_q;
  logic        hit_q;
  logic [2:0]  hitNum_q;
  logic        armed_q;
  logic [3:0]  stillCnt_q, stillCnt_d;
  logic        stopped_q, stopped_d;
  logic        holeHit_q;
  logic [2:0]  holeNum_q;

  // The output comb process drives these FSM control signals.
  logic        fire_d;
  logic [2:0]  num_d;

  // Saturating magnitude of an 11-bit signed value (-1024 maps to 1023)
  function automatic logic [10:0] abs11(input logic [10:0] v);
    if (!v[10])        return v;
    if (v == 11'h400)  return 11'h3FF;
    return 11'(-v);
  endfunction

  // Geometry: centre of the hole currently being scanned
  logic [10:0] hx, hy;
  always_comb begin
    hx = TABLE_LEFT;
    hy = TABLE_TOP;
    case (idx_q)
      3'd1: begin hx = TABLE_LEFT;  hy = TABLE_TOP;    end
      3'd2: begin hx = TABLE_MID;   hy = TABLE_TOP;    end
      3'd3: begin hx = TABLE_RIGHT; hy = TABLE_TOP;    end
      3'd4: begin hx = TABLE_LEFT;  hy = TABLE_BOTTOM; end
      3'd5: begin hx = TABLE_MID;   hy = TABLE_BOTTOM; end
      3'd6: begin hx = TABLE_RIGHT; hy = TABLE_BOTTOM; end
      default: begin hx = TABLE_LEFT; hy = TABLE_TOP; end
    endcase
  end

  // Squared distance from the sampled ball centre to the current hole
  logic [11:0] dx, dy, ax, ay;
  logic [23:0] d2;
  logic        hole_in;
  always_comb begin
    dx = {1'b0, x_q} - {1'b0, hx};
    dy = {1'b0, y_q} - {1'b0, hy};
    ax = dx[11] ? 12'(-dx) : dx;
    ay = dy[11] ? 12'(-dy) : dy;
    d2 = ({12'd0, ax} * {12'd0, ax}) + ({12'd0, ay} * {12'd0, ay});
    hole_in = (d2 <= R2);
  end

  // The stop decision is taken on the sampling edge itself, so the level
  // updates in the first scan cycle of the frame.
  logic still_in;
  always_comb begin
    still_in = ballShow && (abs11(ballSpeedX) <= SPEED_EPS)
                        && (abs11(ballSpeedY) <= SPEED_EPS);
    stillCnt_d = 4'd0;
    stopped_d  = 1'b0;
    if (still_in) begin
      stillCnt_d = (stillCnt_q >= STOP_FRAMES) ? STOP_FRAMES : stillCnt_q + 4'd1;
      stopped_d  = (stillCnt_d == STOP_FRAMES);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: a strobe always (re)starts a scan
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (startOfFrame) state_d = S_SCAN;
      S_SCAN:   if (startOfFrame) state_d = S_SCAN;
                else if (idx_q == 3'd6) state_d = S_REPORT;
      S_REPORT: state_d = startOfFrame ? S_SCAN : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: the pulse is decided on the last scan cycle and registered,
  // so it shows up in the report cycle with no input-to-output path.
  // A strobe on that last cycle aborts the frame before the pulse forms.
  always_comb begin
    num_d  = hit_q ? hitNum_q : idx_q;
    fire_d = (state_q == S_SCAN) && (idx_q == 3'd6) && !startOfFrame &&
             (hit_q || hole_in) && show_q && armed_q;
  end

  // Datapath: sampling, scan bookkeeping, arming and stop debounce
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      show_q     <= 1'b0;
      idx_q      <= 3'd0;
      hit_q      <= 1'b0;
      hitNum_q   <= 3'd0;
      armed_q    <= 1'b1;
      stillCnt_q <= 4'd0;
      stopped_q  <= 1'b0;
      holeHit_q  <= 1'b0;
      holeNum_q  <= 3'd0;
    end else begin
      holeHit_q <= fire_d;
      if (fire_d) holeNum_q <= num_d;
      // A disappearance ends the appearance, so it beats the disarm.
      if (!ballShow)      armed_q <= 1'b1;
      else if (holeHit_q) armed_q <= 1'b0;
      if (startOfFrame) begin
        x_q        <= ballX;
        y_q        <= ballY;
        show_q     <= ballShow;
        idx_q      <= 3'd1;
        hit_q      <= 1'b0;
        hitNum_q   <= 3'd0;
        stillCnt_q <= stillCnt_d;
        stopped_q  <= stopped_d;
      end else if (state_q == S_SCAN) begin
        idx_q <= idx_q + 3'd1;
        // The first hit latches its number; lower index wins on overlap.
        if (hole_in && !hit_q) begin
          hit_q    <= 1'b1;
          hitNum_q <= idx_q;
        end
      end
    end
  end

  assign ballHoleHit = holeHit_q;
  assign ballHoleNum = holeNum_q;
  assign ballStopped = stopped_q;

endmodule

// File: tb/tb_ball_event_detector.sv
// Directed bench for ball_event_detector: hole hits, arming, boundaries,
// stop debounce, abort, mid-scan reset and hidden ball.
module tb_ball_event_detector;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        ballShow = 1'b0;
  logic [10:0] ballX = '0, ballY = '0, ballSpeedX = '0, ballSpeedY = '0;
  logic        ballHoleHit;
  logic [2:0]  ballHoleNum;
  logic        ballStopped;

  int passed = 0;
  int total  = 0;

  ball_event_detector dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .ballShow(ballShow),
    .ballX(ballX), .ballY(ballY), .ballSpeedX(ballSpeedX), .ballSpeedY(ballSpeedY),
    .ballHoleHit(ballHoleHit), .ballHoleNum(ballHoleNum), .ballStopped(ballStopped)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Strobe one frame, then watch cycles T+1..T+10.
  // pc is the last cycle with a pulse, np counts pulses, st1 is ballStopped at T+1.
  task automatic frame(input logic [10:0] x, input logic [10:0] y, input logic s,
                       input logic [10:0] vx, input logic [10:0] vy,
                       output int pc, output int np, output logic st1);
    ballX = x; ballY = y; ballShow = s; ballSpeedX = vx; ballSpeedY = vy;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    st1 = ballStopped;
    pc = -1;
    np = 0;
    for (int c = 1; c <= 10; c++) begin
      if (ballHoleHit !== 1'b0) begin np++; pc = c; end
      tick();
    end
  endtask

  task automatic rearm();
    ballShow = 1'b0;
    tick();
    ballShow = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int pc, np, cnt;
    logic st1;

    // Reset state
    do_reset();
    chk("rst_hit", 32'(ballHoleHit), 32'd0);
    chk("rst_num", 32'(ballHoleNum), 32'd0);
    chk("rst_stop", 32'(ballStopped), 32'd0);

    // 1: hole 1 hit, armed gating, re-arm
    frame(11'd32, 11'd64, 1'b1, 11'd0, 11'd0, pc, np, st1);
    chk("h1_cyc", 32'(pc), 32'd7);
    chk("h1_np", 32'(np), 32'd1);
    chk("h1_num", 32'(ballHoleNum), 32'd1);
    frame(11'd32, 11'd64, 1'b1, 11'd0, 11'd0, pc, np, st1);
    chk("h1_disarmed_np", 32'(np), 32'd0);
    rearm();
    frame(11'd32, 11'd64, 1'b1, 11'd0, 11'd0, pc, np, st1);
    chk("h1_rearm_cyc", 32'(pc), 32'd7);
    chk("h1_rearm_num", 32'(ballHoleNum), 32'd1);

    // 2: radius boundary and middle hole
    rearm();
    frame(11'd44, 11'd64, 1'b1, 11'd0, 11'd0, pc, np, st1);
    chk("b144_np", 32'(np), 32'd1);
    chk("b144_num", 32'(ballHoleNum), 32'd1);
    rearm();
    frame(11'd45, 11'd64, 1'b1, 11'd0, 11'd0, pc, np, st1);
    chk("b169_np", 32'(np), 32'd0);
    rearm();
    frame(11'd327, 11'd447, 1'b1, 11'd0, 11'd0, pc, np, st1);
    chk("h5_cyc", 32'(pc), 32'd7);
    chk("h5_num", 32'(ballHoleNum), 32'd5);

    // 3: stop debounce from a clean counter
    do_reset();
    for (int f = 1; f <= 3; f++) begin
      frame(11'd200, 11'd200, 1'b1, 11'd0, 11'd0, pc, np, st1);
      chk("st3_still", 32'(st1), 32'd0);
    end
    frame(11'd200, 11'd200, 1'b1, 11'd1, 11'd0, pc, np, st1);
    chk("st_vx1", 32'(st1), 32'd0);
    for (int f = 1; f <= 4; f++) begin
      frame(11'd200, 11'd200, 1'b1, 11'd0, 11'd0, pc, np, st1);
      chk("st4_seq", 32'(st1), (f == 4) ? 32'd1 : 32'd0);
    end
    chk("st_hold", 32'(ballStopped), 32'd1);
    frame(11'd200, 11'd200, 1'b1, 11'd0, 11'h7FF, pc, np, st1);
    chk("st_vym1", 32'(st1), 32'd0);
    frame(11'd200, 11'd200, 1'b1, 11'h400, 11'd0, pc, np, st1);
    chk("st_vxmin", 32'(st1), 32'd0);

    // 4: abort at T+3 moves the ball off hole 3
    ballX = 11'd607; ballY = 11'd64; ballShow = 1'b1; ballSpeedX = '0; ballSpeedY = '0;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    tick();
    ballX = 11'd200; ballY = 11'd200;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    cnt = 0;
    for (int c = 0; c < 14; c++) begin
      if (ballHoleHit !== 1'b0) cnt++;
      tick();
    end
    chk("abort_np", 32'(cnt), 32'd0);

    // 5: reset at T+4 of a hitting frame (hole 4)
    ballX = 11'd32; ballY = 11'd447;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_hit", 32'(ballHoleHit), 32'd0);
    chk("mrst_num", 32'(ballHoleNum), 32'd0);
    chk("mrst_stop", 32'(ballStopped), 32'd0);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (ballHoleHit !== 1'b0) cnt++;
      tick();
    end
    chk("mrst_np", 32'(cnt), 32'd0);
    frame(11'd32, 11'd447, 1'b1, 11'd0, 11'd0, pc, np, st1);
    chk("mrst_next_cyc", 32'(pc), 32'd7);
    chk("mrst_next_num", 32'(ballHoleNum), 32'd4);

    // 6: hidden ball over hole 6, still speeds
    for (int f = 1; f <= 6; f++) begin
      frame(11'd607, 11'd447, 1'b0, 11'd0, 11'd0, pc, np, st1);
      chk("hid_np", 32'(np), 32'd0);
      chk("hid_stop", 32'(st1), 32'd0);
    end
    chk("hid_stop_end", 32'(ballStopped), 32'd0);
    chk("hid_num_held", 32'(ballHoleNum), 32'd4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
